// File: rtl/bypass_dma_responder_if.sv
// Descriptor, completion and data-stream signals of the bypass DMA responder.
// The responder attaches through the slave modport; the requester side uses master.
interface bypass_dma_responder_if #(
   parameter int DATA_BITS = 512,
   parameter int REQ_BITS  = 96
);
   logic                   s_rd_req_valid;
   logic                   s_rd_req_ready;
   logic [REQ_BITS-1:0]    s_rd_req_data;
   logic                   s_wr_req_valid;
   logic                   s_wr_req_ready;
   logic [REQ_BITS-1:0]    s_wr_req_data;
   logic                   m_rd_done_valid;
   logic                   m_rd_done_ready;
   logic [15:0]            m_rd_done_data;
   logic                   m_wr_done_valid;
   logic                   m_wr_done_ready;
   logic [15:0]            m_wr_done_data;
   logic [DATA_BITS-1:0]   m_axis_rd_tdata;
   logic [DATA_BITS/8-1:0] m_axis_rd_tkeep;
   logic                   m_axis_rd_tlast;
   logic                   m_axis_rd_tvalid;
   logic                   m_axis_rd_tready;
   logic [5:0]             m_axis_rd_tid;
   logic [DATA_BITS-1:0]   s_axis_wr_tdata;
   logic [DATA_BITS/8-1:0] s_axis_wr_tkeep;
   logic                   s_axis_wr_tlast;
   logic                   s_axis_wr_tvalid;
   logic                   s_axis_wr_tready;

   modport master (
      output s_rd_req_valid, s_rd_req_data, input s_rd_req_ready,
      output s_wr_req_valid, s_wr_req_data, input s_wr_req_ready,
      input  m_rd_done_valid, m_rd_done_data, output m_rd_done_ready,
      input  m_wr_done_valid, m_wr_done_data, output m_wr_done_ready,
      input  m_axis_rd_tdata, m_axis_rd_tkeep, m_axis_rd_tlast, m_axis_rd_tvalid, m_axis_rd_tid,
      output m_axis_rd_tready,
      output s_axis_wr_tdata, s_axis_wr_tkeep, s_axis_wr_tlast, s_axis_wr_tvalid,
      input  s_axis_wr_tready
   );

   modport slave (
      input  s_rd_req_valid, s_rd_req_data, output s_rd_req_ready,
      input  s_wr_req_valid, s_wr_req_data, output s_wr_req_ready,
      output m_rd_done_valid, m_rd_done_data, input m_rd_done_ready,
      output m_wr_done_valid, m_wr_done_data, input m_wr_done_ready,
      output m_axis_rd_tdata, m_axis_rd_tkeep, m_axis_rd_tlast, m_axis_rd_tvalid, m_axis_rd_tid,
      input  m_axis_rd_tready,
      input  s_axis_wr_tdata, s_axis_wr_tkeep, s_axis_wr_tlast, s_axis_wr_tvalid,
      output s_axis_wr_tready
   );
endinterface

// File: rtl/bypass_dma_responder.sv
// Loopback-style DMA responder: reads return an address-derived byte ramp, writes are
// consumed and checked for framing. Each channel is an independent IDLE/DATA/DONE FSM.
module bypass_dma_responder #(
   parameter int DATA_BITS = 512,
   parameter int REQ_BITS  = 96
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   bypass_dma_responder_if.slave bus
);
   localparam int             BYTES   = DATA_BITS / 8;
   localparam int             KB      = $clog2(BYTES);
   localparam logic [7:0]     BYTES_B = 8'(BYTES);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_DONE} state_t;

   // Last-beat keep: low (len mod BYTES) lanes, or every lane when the remainder is zero.
   function automatic logic [BYTES-1:0] keep_mask(input logic [KB-1:0] rem);
      logic [BYTES-1:0] m;
      m = '0;
      for (int k = 0; k < BYTES; k++) m[k] = (rem == '0) || (k < int'(rem));
      return m;
   endfunction

   // ---------------- read channel ----------------
   state_t               r_rd_state;
   logic                 r_rd_req_ready, r_rd_tvalid, r_rd_tlast, r_rd_ctl, r_rd_done_valid;
   logic [DATA_BITS-1:0] r_rd_tdata;
   logic [BYTES-1:0]     r_rd_tkeep;
   logic [5:0]           r_rd_tid;
   logic [3:0]           r_rd_dest;
   logic [27:0]          r_rd_cnt;
   logic [7:0]           r_rd_base;
   logic [KB-1:0]        r_rd_rem;
   logic [15:0]          r_rd_done_data;

   logic                 w_rd_req_fire, w_rd_beat_fire;
   logic [27:0]          w_rd_len, w_rd_beats;
   logic [28:0]          w_rd_sum;
   logic [7:0]           w_rd_next_base;
   logic [DATA_BITS-1:0] w_rd_next_tdata;
   logic                 w_unused_rd;

   assign w_rd_req_fire  = bus.s_rd_req_valid && r_rd_req_ready;
   assign w_rd_beat_fire = r_rd_tvalid && bus.m_axis_rd_tready;
   assign w_rd_len       = bus.s_rd_req_data[75:48];
   assign w_rd_sum       = {1'b0, w_rd_len} + 29'(BYTES - 1);
   assign w_rd_beats     = 28'(w_rd_sum >> KB);
   assign w_rd_next_base = (r_rd_state == S_IDLE) ? bus.s_rd_req_data[7:0] : r_rd_base + BYTES_B;
   assign w_unused_rd    = ^{bus.s_rd_req_data[REQ_BITS-1:87], bus.s_rd_req_data[47:8]};

   for (genvar gi = 0; gi < BYTES; gi++) begin : g_rd_lane
      assign w_rd_next_tdata[gi*8 +: 8] = w_rd_next_base + 8'(gi);
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rd_state      <= S_IDLE;
         r_rd_req_ready  <= 1'b0;
         r_rd_tvalid     <= 1'b0;
         r_rd_tlast      <= 1'b0;
         r_rd_ctl        <= 1'b0;
         r_rd_done_valid <= 1'b0;
         r_rd_tdata      <= '0;
         r_rd_tkeep      <= '0;
         r_rd_tid        <= '0;
         r_rd_dest       <= '0;
         r_rd_cnt        <= '0;
         r_rd_base       <= '0;
         r_rd_rem        <= '0;
         r_rd_done_data  <= '0;
      end else begin
         case (r_rd_state)
            S_IDLE: begin
               r_rd_req_ready <= 1'b1;
               if (w_rd_req_fire) begin
                  r_rd_req_ready <= 1'b0;
                  r_rd_ctl       <= bus.s_rd_req_data[76];
                  r_rd_tid       <= bus.s_rd_req_data[82:77];
                  r_rd_dest      <= bus.s_rd_req_data[86:83];
                  r_rd_rem       <= w_rd_len[KB-1:0];
                  r_rd_cnt       <= w_rd_beats;
                  r_rd_base      <= w_rd_next_base;
                  r_rd_tdata     <= w_rd_next_tdata;
                  r_rd_tkeep     <= (w_rd_beats == 28'd1) ? keep_mask(w_rd_len[KB-1:0]) : '1;
                  r_rd_tlast     <= (w_rd_beats == 28'd1);
                  if (w_rd_len == '0) begin
                     // Empty read: no beats, completion flags the error.
                     if (bus.s_rd_req_data[76]) begin
                        r_rd_state      <= S_DONE;
                        r_rd_done_valid <= 1'b1;
                        r_rd_done_data  <= {5'b0, 1'b1, bus.s_rd_req_data[86:83],
                                            bus.s_rd_req_data[82:77]};
                     end else begin
                        r_rd_req_ready <= 1'b1;
                     end
                  end else begin
                     r_rd_state  <= S_DATA;
                     r_rd_tvalid <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (w_rd_beat_fire) begin
                  if (r_rd_cnt == 28'd1) begin
                     r_rd_tvalid <= 1'b0;
                     r_rd_tlast  <= 1'b0;
                     r_rd_cnt    <= '0;
                     if (r_rd_ctl) begin
                        r_rd_state      <= S_DONE;
                        r_rd_done_valid <= 1'b1;
                        r_rd_done_data  <= {5'b0, 1'b0, r_rd_dest, r_rd_tid};
                     end else begin
                        r_rd_state     <= S_IDLE;
                        r_rd_req_ready <= 1'b1;
                     end
                  end else begin
                     r_rd_cnt   <= r_rd_cnt - 28'd1;
                     r_rd_base  <= w_rd_next_base;
                     r_rd_tdata <= w_rd_next_tdata;
                     r_rd_tkeep <= (r_rd_cnt == 28'd2) ? keep_mask(r_rd_rem) : '1;
                     r_rd_tlast <= (r_rd_cnt == 28'd2);
                  end
               end
            end
            S_DONE: begin
               if (bus.m_rd_done_ready) begin
                  r_rd_done_valid <= 1'b0;
                  r_rd_state      <= S_IDLE;
                  r_rd_req_ready  <= 1'b1;
               end
            end
            default: r_rd_state <= S_IDLE;
         endcase
      end
   end

   assign bus.s_rd_req_ready   = r_rd_req_ready;
   assign bus.m_axis_rd_tvalid = r_rd_tvalid;
   assign bus.m_axis_rd_tdata  = r_rd_tdata;
   assign bus.m_axis_rd_tkeep  = r_rd_tkeep;
   assign bus.m_axis_rd_tlast  = r_rd_tlast;
   assign bus.m_axis_rd_tid    = r_rd_tid;
   assign bus.m_rd_done_valid  = r_rd_done_valid;
   assign bus.m_rd_done_data   = r_rd_done_data;

   // ---------------- write channel ----------------
   state_t           r_wr_state;
   logic             r_wr_req_ready, r_wr_tready, r_wr_ctl, r_wr_err, r_wr_done_valid;
   logic [5:0]       r_wr_pid;
   logic [3:0]       r_wr_dest;
   logic [27:0]      r_wr_cnt;
   logic [KB-1:0]    r_wr_rem;
   logic [15:0]      r_wr_done_data;

   logic             w_wr_req_fire, w_wr_beat_fire, w_wr_is_last, w_wr_err_next;
   logic [27:0]      w_wr_len, w_wr_beats;
   logic [28:0]      w_wr_sum;
   logic             w_unused_wr;

   assign w_wr_req_fire  = bus.s_wr_req_valid && r_wr_req_ready;
   assign w_wr_beat_fire = r_wr_tready && bus.s_axis_wr_tvalid;
   assign w_wr_len       = bus.s_wr_req_data[75:48];
   assign w_wr_sum       = {1'b0, w_wr_len} + 29'(BYTES - 1);
   assign w_wr_beats     = 28'(w_wr_sum >> KB);
   assign w_wr_is_last   = (r_wr_cnt == 28'd1);
   // Framing error: tlast on the wrong beat, or a last-beat keep that disagrees with len.
   assign w_wr_err_next  = r_wr_err || (bus.s_axis_wr_tlast != w_wr_is_last) ||
                           (w_wr_is_last && (bus.s_axis_wr_tkeep != keep_mask(r_wr_rem)));
   assign w_unused_wr    = ^{bus.s_wr_req_data[REQ_BITS-1:87], bus.s_wr_req_data[47:0],
                             bus.s_axis_wr_tdata};

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wr_state      <= S_IDLE;
         r_wr_req_ready  <= 1'b0;
         r_wr_tready     <= 1'b0;
         r_wr_ctl        <= 1'b0;
         r_wr_err        <= 1'b0;
         r_wr_done_valid <= 1'b0;
         r_wr_pid        <= '0;
         r_wr_dest       <= '0;
         r_wr_cnt        <= '0;
         r_wr_rem        <= '0;
         r_wr_done_data  <= '0;
      end else begin
         case (r_wr_state)
            S_IDLE: begin
               r_wr_req_ready <= 1'b1;
               if (w_wr_req_fire) begin
                  r_wr_req_ready <= 1'b0;
                  r_wr_ctl       <= bus.s_wr_req_data[76];
                  r_wr_pid       <= bus.s_wr_req_data[82:77];
                  r_wr_dest      <= bus.s_wr_req_data[86:83];
                  r_wr_rem       <= w_wr_len[KB-1:0];
                  r_wr_cnt       <= w_wr_beats;
                  r_wr_err       <= (w_wr_len == '0);
                  if (w_wr_len == '0) begin
                     if (bus.s_wr_req_data[76]) begin
                        r_wr_state      <= S_DONE;
                        r_wr_done_valid <= 1'b1;
                        r_wr_done_data  <= {5'b0, 1'b1, bus.s_wr_req_data[86:83],
                                            bus.s_wr_req_data[82:77]};
                     end else begin
                        r_wr_req_ready <= 1'b1;
                     end
                  end else begin
                     r_wr_state  <= S_DATA;
                     r_wr_tready <= 1'b1;
                  end
               end
            end
            S_DATA: begin
               if (w_wr_beat_fire) begin
                  r_wr_err <= w_wr_err_next;
                  if (w_wr_is_last) begin
                     r_wr_tready <= 1'b0;
                     r_wr_cnt    <= '0;
                     if (r_wr_ctl) begin
                        r_wr_state      <= S_DONE;
                        r_wr_done_valid <= 1'b1;
                        r_wr_done_data  <= {5'b0, w_wr_err_next, r_wr_dest, r_wr_pid};
                     end else begin
                        r_wr_state     <= S_IDLE;
                        r_wr_req_ready <= 1'b1;
                     end
                  end else begin
                     r_wr_cnt <= r_wr_cnt - 28'd1;
                  end
               end
            end
            S_DONE: begin
               if (bus.m_wr_done_ready) begin
                  r_wr_done_valid <= 1'b0;
                  r_wr_state      <= S_IDLE;
                  r_wr_req_ready  <= 1'b1;
               end
            end
            default: r_wr_state <= S_IDLE;
         endcase
      end
   end

   assign bus.s_wr_req_ready   = r_wr_req_ready;
   assign bus.s_axis_wr_tready = r_wr_tready;
   assign bus.m_wr_done_valid  = r_wr_done_valid;
   assign bus.m_wr_done_data   = r_wr_done_data;
endmodule

// File: tb/tb_bypass_dma_responder.sv
// Directed bench for bypass_dma_responder: drivers push expected beats/completions into
// queues, independent monitors pop and compare on every handshake.
module tb_bypass_dma_responder;
   localparam int DB = 512;
   localparam int NB = DB / 8;

   logic aclk;
   logic aresetn;
   int   n_tests = 0;
   int   n_fail  = 0;

   bypass_dma_responder_if #(.DATA_BITS(DB), .REQ_BITS(96)) bus ();

   bypass_dma_responder #(.DATA_BITS(DB), .REQ_BITS(96)) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus.slave)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   typedef struct {
      logic [7:0]    base;
      logic [NB-1:0] keep;
      logic          last;
      logic [5:0]    tid;
   } beat_t;

   beat_t       q_beat[$];
   logic [15:0] q_rd_done[$];
   logic [15:0] q_wr_done[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [95:0] desc(input logic [47:0] va, input logic [27:0] len,
                                        input logic ctl, input logic [5:0] pid,
                                        input logic [3:0] dest, input logic [8:0] junk);
      return {junk, dest, pid, ctl, len, va};
   endfunction

   function automatic beat_t mk_beat(input logic [7:0] base, input logic [NB-1:0] keep,
                                     input logic last, input logic [5:0] tid);
      beat_t b;
      b.base = base; b.keep = keep; b.last = last; b.tid = tid;
      return b;
   endfunction

   // Read-stream monitor: compares each accepted beat and checks stability under stall.
   initial begin
      beat_t         b;
      logic [DB-1:0] exp_d;
      logic          held;
      logic [DB-1:0] h_data;
      logic [NB-1:0] h_keep;
      logic          h_last;
      logic [5:0]    h_tid;
      held = 1'b0;
      forever begin
         @(negedge aclk);
         if (aresetn && bus.m_axis_rd_tvalid) begin
            if (held) begin
               n_tests++;
               if (bus.m_axis_rd_tdata !== h_data || bus.m_axis_rd_tkeep !== h_keep ||
                   bus.m_axis_rd_tlast !== h_last || bus.m_axis_rd_tid !== h_tid) begin
                  n_fail++;
                  $display("FAIL rd_stall_stable: byte0 0x%0h keep 0x%0h last %0b, held byte0 0x%0h keep 0x%0h last %0b",
                           bus.m_axis_rd_tdata[7:0], bus.m_axis_rd_tkeep, bus.m_axis_rd_tlast,
                           h_data[7:0], h_keep, h_last);
               end
            end
            if (bus.m_axis_rd_tready) begin
               if (q_beat.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL rd_beat_unexpected: byte0 0x%0h, expected no beat", bus.m_axis_rd_tdata[7:0]);
               end else begin
                  b = q_beat.pop_front();
                  for (int j = 0; j < NB; j++) exp_d[j*8 +: 8] = b.base + 8'(j);
                  n_tests++;
                  if (bus.m_axis_rd_tdata !== exp_d || bus.m_axis_rd_tkeep !== b.keep ||
                      bus.m_axis_rd_tlast !== b.last || bus.m_axis_rd_tid !== b.tid) begin
                     n_fail++;
                     $display("FAIL rd_beat: byte0 0x%0h keep 0x%0h last %0b tid %0d, expected byte0 0x%0h keep 0x%0h last %0b tid %0d",
                              bus.m_axis_rd_tdata[7:0], bus.m_axis_rd_tkeep, bus.m_axis_rd_tlast,
                              bus.m_axis_rd_tid, b.base, b.keep, b.last, b.tid);
                  end
               end
            end
            held   = !bus.m_axis_rd_tready;
            h_data = bus.m_axis_rd_tdata;
            h_keep = bus.m_axis_rd_tkeep;
            h_last = bus.m_axis_rd_tlast;
            h_tid  = bus.m_axis_rd_tid;
         end else begin
            held = 1'b0;
         end
      end
   end

   // Completion monitors, one per channel.
   initial begin
      logic [15:0] e;
      logic        held;
      logic [15:0] h;
      held = 1'b0;
      forever begin
         @(negedge aclk);
         if (aresetn && bus.m_rd_done_valid) begin
            if (held) chk("rd_done_stable", 64'(bus.m_rd_done_data), 64'(h));
            if (bus.m_rd_done_ready) begin
               if (q_rd_done.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL rd_done_unexpected: got 0x%0h, expected no done", bus.m_rd_done_data);
               end else begin
                  e = q_rd_done.pop_front();
                  chk("rd_done_data", 64'(bus.m_rd_done_data), 64'(e));
               end
            end
            held = !bus.m_rd_done_ready;
            h    = bus.m_rd_done_data;
         end else held = 1'b0;
      end
   end

   initial begin
      logic [15:0] e;
      logic        held;
      logic [15:0] h;
      held = 1'b0;
      forever begin
         @(negedge aclk);
         if (aresetn && bus.m_wr_done_valid) begin
            if (held) chk("wr_done_stable", 64'(bus.m_wr_done_data), 64'(h));
            if (bus.m_wr_done_ready) begin
               if (q_wr_done.size() == 0) begin
                  n_tests++; n_fail++;
                  $display("FAIL wr_done_unexpected: got 0x%0h, expected no done", bus.m_wr_done_data);
               end else begin
                  e = q_wr_done.pop_front();
                  chk("wr_done_data", 64'(bus.m_wr_done_data), 64'(e));
               end
            end
            held = !bus.m_wr_done_ready;
            h    = bus.m_wr_done_data;
         end else held = 1'b0;
      end
   end

   // Tasks are entered and leave 1 time unit after a rising edge.
   task automatic send_rd(input logic [95:0] d);
      int k;
      bus.s_rd_req_valid = 1'b1;
      bus.s_rd_req_data  = d;
      k = 0;
      while (!bus.s_rd_req_ready && k < 50) begin @(posedge aclk); #1; k++; end
      if (k >= 50) begin
         n_tests++; n_fail++;
         $display("FAIL rd_req_timeout: ready 0 after %0d cycles, expected 1", k);
      end
      @(posedge aclk); #1;
      bus.s_rd_req_valid = 1'b0;
   endtask

   task automatic send_wr(input logic [95:0] d);
      int k;
      bus.s_wr_req_valid = 1'b1;
      bus.s_wr_req_data  = d;
      k = 0;
      while (!bus.s_wr_req_ready && k < 50) begin @(posedge aclk); #1; k++; end
      if (k >= 50) begin
         n_tests++; n_fail++;
         $display("FAIL wr_req_timeout: ready 0 after %0d cycles, expected 1", k);
      end
      @(posedge aclk); #1;
      bus.s_wr_req_valid = 1'b0;
   endtask

   task automatic send_wr_beat(input logic last, input logic [NB-1:0] keep);
      int k;
      bus.s_axis_wr_tvalid = 1'b1;
      bus.s_axis_wr_tlast  = last;
      bus.s_axis_wr_tkeep  = keep;
      bus.s_axis_wr_tdata  = {16{32'hA5A5_0000 + 32'(k)}};
      k = 0;
      while (!bus.s_axis_wr_tready && k < 50) begin @(posedge aclk); #1; k++; end
      if (k >= 50) begin
         n_tests++; n_fail++;
         $display("FAIL wr_beat_timeout: tready 0 after %0d cycles, expected 1", k);
      end
      @(posedge aclk); #1;
      bus.s_axis_wr_tvalid = 1'b0;
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      while ((q_beat.size() + q_rd_done.size() + q_wr_done.size()) != 0 && k < 200) begin
         @(negedge aclk); k++;
      end
      @(posedge aclk); #1;
      chk("drain_pending", 64'(q_beat.size() + q_rd_done.size() + q_wr_done.size()), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      aresetn              = 1'b0;
      bus.s_rd_req_valid   = 1'b0;
      bus.s_rd_req_data    = '0;
      bus.s_wr_req_valid   = 1'b0;
      bus.s_wr_req_data    = '0;
      bus.m_rd_done_ready  = 1'b1;
      bus.m_wr_done_ready  = 1'b1;
      bus.m_axis_rd_tready = 1'b1;
      bus.s_axis_wr_tdata  = '0;
      bus.s_axis_wr_tkeep  = '0;
      bus.s_axis_wr_tlast  = 1'b0;
      bus.s_axis_wr_tvalid = 1'b0;

      // Reset state
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk("rst_rd_req_ready", 64'(bus.s_rd_req_ready), 64'd0);
      chk("rst_wr_req_ready", 64'(bus.s_wr_req_ready), 64'd0);
      chk("rst_rd_tvalid",    64'(bus.m_axis_rd_tvalid), 64'd0);
      chk("rst_wr_tready",    64'(bus.s_axis_wr_tready), 64'd0);
      chk("rst_done_valids",  64'({bus.m_rd_done_valid, bus.m_wr_done_valid}), 64'd0);
      chk("rst_rd_tdata_lo",  64'(bus.m_axis_rd_tdata[63:0]), 64'd0);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("rel_rd_req_ready", 64'(bus.s_rd_req_ready), 64'd1);
      chk("rel_wr_req_ready", 64'(bus.s_wr_req_ready), 64'd1);

      // Read 130 bytes from 0x10: 3 beats, last keep 0x3, junk in the ignored upper bits
      q_beat.push_back(mk_beat(8'h10, '1, 1'b0, 6'd3));
      q_beat.push_back(mk_beat(8'h50, '1, 1'b0, 6'd3));
      q_beat.push_back(mk_beat(8'h90, 64'h3, 1'b1, 6'd3));
      q_rd_done.push_back(16'h003);
      send_rd(desc(48'h10, 28'd130, 1'b1, 6'd3, 4'd0, 9'h1FF));
      chk("rd_first_tvalid_latency", 64'(bus.m_axis_rd_tvalid), 64'd1);
      chk("rd_req_ready_busy",       64'(bus.s_rd_req_ready), 64'd0);
      wait_drain();

      // Write 128 bytes, dest 2: correct framing, then tlast on the wrong beat
      q_wr_done.push_back(16'h080);
      send_wr(desc(48'h0, 28'd128, 1'b1, 6'd0, 4'd2, 9'h0));
      chk("wr_tready_latency", 64'(bus.s_axis_wr_tready), 64'd1);
      send_wr_beat(1'b0, '1);
      send_wr_beat(1'b1, '1);
      chk("wr_done_latency", 64'(bus.m_wr_done_valid), 64'd1);
      q_wr_done.push_back(16'h480);
      send_wr(desc(48'h0, 28'd128, 1'b1, 6'd0, 4'd2, 9'h0));
      send_wr_beat(1'b1, '1);
      send_wr_beat(1'b0, '1);
      wait_drain();

      // Write 100 bytes: last-beat keep must be 0xF_FFFF_FFFF; give 0xFF -> err
      q_wr_done.push_back(16'h400 | (16'd1 << 6) | 16'd5);
      send_wr(desc(48'h0, 28'd100, 1'b1, 6'd5, 4'd1, 9'h0));
      send_wr_beat(1'b0, '1);
      send_wr_beat(1'b1, 64'hFF);
      wait_drain();

      // Read 64 bytes, tready toggling, ctl=0: one full beat, no completion
      bus.m_axis_rd_tready = 1'b0;
      q_beat.push_back(mk_beat(8'h20, '1, 1'b1, 6'd5));
      send_rd(desc(48'h20, 28'd64, 1'b0, 6'd5, 4'd0, 9'h0));
      k = 0;
      while (q_beat.size() != 0 && k < 20) begin
         @(posedge aclk); #1;
         bus.m_axis_rd_tready = ~bus.m_axis_rd_tready;
         k++;
      end
      chk("ctl0_req_ready_next", 64'(bus.s_rd_req_ready), 64'd1);
      chk("ctl0_tvalid_low",     64'(bus.m_axis_rd_tvalid), 64'd0);
      repeat (4) @(posedge aclk);
      #1;
      chk("ctl0_no_done", 64'(bus.m_rd_done_valid), 64'd0);
      bus.m_axis_rd_tready = 1'b1;

      // len=0 on both channels at once; write done held off must not block read done
      bus.m_wr_done_ready = 1'b0;
      q_rd_done.push_back(16'h447);
      q_wr_done.push_back(16'h4C9);
      fork
         send_rd(desc(48'h0, 28'd0, 1'b1, 6'd7, 4'd1, 9'h0));
         send_wr(desc(48'h0, 28'd0, 1'b1, 6'd9, 4'd3, 9'h0));
      join
      chk("len0_rd_no_tvalid", 64'(bus.m_axis_rd_tvalid), 64'd0);
      chk("len0_wr_no_tready", 64'(bus.s_axis_wr_tready), 64'd0);
      chk("len0_both_done_valid", 64'({bus.m_rd_done_valid, bus.m_wr_done_valid}), 64'd3);
      k = 0;
      while (q_rd_done.size() != 0 && k < 20) begin @(negedge aclk); k++; end
      @(posedge aclk); #1;
      chk("len0_rd_ready_while_wr_stalled", 64'(bus.s_rd_req_ready), 64'd1);
      chk("len0_wr_done_still_valid",       64'(bus.m_wr_done_valid), 64'd1);
      repeat (3) @(posedge aclk);
      #1;
      bus.m_wr_done_ready = 1'b1;
      wait_drain();

      // Reset during beat 2 of a 4-beat read
      q_beat.push_back(mk_beat(8'h00, '1, 1'b0, 6'd2));
      send_rd(desc(48'h0, 28'd256, 1'b1, 6'd2, 4'd0, 9'h0));
      @(posedge aclk); #1;
      bus.m_axis_rd_tready = 1'b0;
      @(negedge aclk); #1;
      chk("abort_beat2_shown", 64'(bus.m_axis_rd_tvalid), 64'd1);
      aresetn = 1'b0;
      #1;
      chk("abort_tvalid_same_cycle", 64'(bus.m_axis_rd_tvalid), 64'd0);
      chk("abort_no_done",           64'(bus.m_rd_done_valid), 64'd0);
      chk("abort_req_ready_low",     64'(bus.s_rd_req_ready), 64'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      bus.m_axis_rd_tready = 1'b1;
      @(posedge aclk); #1;
      chk("abort_req_ready_rise", 64'(bus.s_rd_req_ready), 64'd1);
      // Fresh read wrapping the byte ramp: 0xF0 + 64 -> 0x30, 70 bytes -> keep 0x3F
      q_beat.push_back(mk_beat(8'hF0, '1, 1'b0, 6'd4));
      q_beat.push_back(mk_beat(8'h30, 64'h3F, 1'b1, 6'd4));
      q_rd_done.push_back(16'h004);
      send_rd(desc(48'h1234_5678_9AF0, 28'd70, 1'b1, 6'd4, 4'd0, 9'h0));
      wait_drain();
      repeat (3) @(posedge aclk);
      #1;
      chk("end_idle_rd_done", 64'(bus.m_rd_done_valid), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bypass_dma_responder.md
BYPASS_DMA_RESPONDER -- requirements
Module: bypass_dma_responder

Interface
REQ-001 SHALL have parameters: DATA_BITS, default 512, stream width in bits; REQ_BITS, default 96, descriptor width in bits.
REQ-002 SHALL have port aclk, input, 1 bit: sole clock; all logic is rising-edge.
REQ-003 SHALL have port aresetn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port s_rd_req_valid/ready/data, in/out/in, 1/1/REQ_BITS: read descriptor.
REQ-005 SHALL have port s_wr_req_valid/ready/data, in/out/in, 1/1/REQ_BITS: write descriptor.
REQ-006 SHALL have port m_rd_done_valid/ready/data, out/in/out, 1/1/16: read completion.
REQ-007 SHALL have port m_wr_done_valid/ready/data, out/in/out, 1/1/16: write completion.
REQ-008 SHALL have port m_axis_rd_tdata/tkeep/tlast/tvalid/tready/tid, out/out/out/out/in/out, DATA_BITS/DATA_BITS/8/1/1/1/6: read data stream.
REQ-009 SHALL have port s_axis_wr_tdata/tkeep/tlast/tvalid/tready, in/in/in/in/out, DATA_BITS/DATA_BITS/8/1/1/1: write data stream.

Function
REQ-010 SHALL decode descriptor fields: vaddr[47:0], len[75:48] in bytes, ctl[76], pid[82:77], dest[86:83]; bits above 86 SHALL be ignored.
REQ-011 SHALL encode done data as: pid[5:0], dest[9:6], err[10], zeros[15:11].
REQ-012 SHALL run read and write channels as independent FSMs, each IDLE -> DATA -> DONE -> IDLE, with no shared state.
REQ-013 SHALL assert req_ready only in IDLE; a descriptor SHALL be captured on valid&&ready, moving the channel to DATA on the next cycle.
REQ-014 SHALL set beat count B = ceil(len/(DATA_BITS/8)), held in a 28-bit down-counter.
REQ-015 In read DATA, SHALL assert tvalid in the first DATA cycle, hold tdata/tkeep/tlast/tid stable until tready, and advance one beat per tvalid&&tready.
REQ-016 SHALL set read byte j of beat i to (vaddr[7:0] + i*(DATA_BITS/8) + j) mod 256, and tid to pid.
REQ-017 SHALL assert tkeep all-ones except on the last beat, where tkeep is ones in the low (len mod 64) bytes, or all-ones if the remainder is 0; tlast SHALL be set only on the last beat.
REQ-018 In write DATA, SHALL assert s_axis_wr_tready and consume exactly B beats.
REQ-019 SHALL set a sticky write err if tlast differs from (beat==last) on any beat, or if last-beat tkeep differs from the REQ-017 mask; consumption SHALL still total B beats.
REQ-020 SHALL treat len==0 as B=0: no data beats, straight to DONE, err=1.
REQ-021 After the final beat, ctl=1 SHALL enter DONE and assert done_valid until done_ready; ctl=0 SHALL return to IDLE without a done.
REQ-022 SHALL keep done_data stable while done_valid is high; err SHALL be 0 for reads with len>0.
REQ-023 SHALL add latency of 1 cycle from descriptor handshake to first read tvalid, and 1 cycle from final data handshake to done_valid.
REQ-024 SHALL allow the next descriptor to be accepted only in the cycle after the done handshake (or after the final beat when ctl=0).
REQ-025 Simultaneous read and write activity SHALL NOT interact; done_ready held low SHALL stall only its own channel.

Reset
REQ-026 SHALL, on aresetn low, immediately clear both FSMs to IDLE, all valid/tvalid/tready/ready outputs to 0, counters and err to 0, and data outputs to 0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer with no done emitted; after release, req_ready SHALL rise on the first clock edge.

Verification
REQ-028 Read vaddr=0x10, len=130, ctl=1, pid=3 -> 3 beats; beat0 byte0=0x10; last tkeep=0x3; tid=3; rd_done data=0x003.
REQ-029 Write len=128, ctl=1, dest=2, 2 beats with tlast on beat1 -> wr_done data=0x080 (err=0); tlast on beat0 instead -> data=0x480.
REQ-030 Read len=64 with tready toggling 1/0 -> exactly 1 beat, tkeep all-ones, tlast=1, stable while stalled; ctl=0 -> no done, req_ready high next cycle.
REQ-031 len=0, ctl=1 on both channels in the same cycle -> no data beats; both dones err=1, independent of each other's done_ready.
REQ-032 aresetn low during read beat 2 of 4 -> tvalid=0 the same cycle; no done; after release, a new descriptor is accepted and is correct.
